// File: rtl/dac_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// dac_ctrl_pkg -- shared FSM encoding and counter width for the DAC frame path
// Revision: 1.0
// =============================================================================
package dac_ctrl_pkg;

  localparam int c_cnt_width = 16;

  typedef logic [c_cnt_width-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// =============================================================================
// rr_arbiter2 -- two-requester round-robin grant with last-grant register
// Revision: 1.0
// =============================================================================
module rr_arbiter2 (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_idx
);

  logic r_last_grant;

  always_comb begin
    grant_idx = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~r_last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

  // Resetting to 1 makes the first contended grant go to requester 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last_grant <= 1'b1;
    end else if (grant_en && (req != 2'b00)) begin
      r_last_grant <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_dac_frame_arbiter.sv
`default_nettype none
// =============================================================================
// axis_dac_frame_arbiter -- two-source AXIS frame arbiter feeding the DAC
// Revision: 1.0
// =============================================================================
module axis_dac_frame_arbiter
  import dac_ctrl_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int GAP_CYCLES       = 16,
  parameter int MAX_FRAME_LEN    = 4096
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic                        s0_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                        s0_axis_tvalid,
  input  logic                        s0_axis_tlast,
  output logic                        s1_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                        s1_axis_tvalid,
  input  logic                        s1_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        frame_trigger,
  output logic                        frame_src,
  output logic                        busy,
  input  logic                        err_clr,
  output logic                        underrun_err,
  output logic                        overlen_err
);

  localparam cnt_t c_max_last = cnt_t'(MAX_FRAME_LEN - 1);
  localparam cnt_t c_gap_load = cnt_t'(GAP_CYCLES);

  state_t r_state;
  cnt_t   r_beat_cnt;
  cnt_t   r_gap_cnt;
  logic   r_src;
  logic   r_trig;
  logic   r_underrun;
  logic   r_overlen;

  logic w_stream;
  logic w_grant_idx;
  logic w_any_req;
  logic w_sel_tvalid;
  logic w_sel_tlast;
  logic w_force_last;
  logic w_hs;

  assign w_stream     = (r_state == ST_STREAM);
  assign w_any_req    = s0_axis_tvalid | s1_axis_tvalid;
  assign w_sel_tvalid = r_src ? s1_axis_tvalid : s0_axis_tvalid;
  assign w_sel_tlast  = r_src ? s1_axis_tlast  : s0_axis_tlast;
  assign w_force_last = (r_beat_cnt == c_max_last);
  assign w_hs         = w_stream & w_sel_tvalid & m_axis_tready;

  rr_arbiter2 u_rr_arbiter2 (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req       ({s1_axis_tvalid, s0_axis_tvalid}),
    .grant_en  (r_state == ST_IDLE),
    .grant_idx (w_grant_idx)
  );

  // Granted source is a zero-latency pass-through; everything else is held off.
  assign m_axis_tdata   = r_src ? s1_axis_tdata : s0_axis_tdata;
  assign m_axis_tvalid  = w_stream & w_sel_tvalid;
  assign m_axis_tlast   = w_stream & (w_sel_tlast | w_force_last);
  assign s0_axis_tready = w_stream & ~r_src & m_axis_tready;
  assign s1_axis_tready = w_stream &  r_src & m_axis_tready;

  assign frame_trigger = r_trig;
  assign frame_src     = r_src;
  assign busy          = (r_state != ST_IDLE);
  assign underrun_err  = r_underrun;
  assign overlen_err   = r_overlen;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
      r_src      <= 1'b0;
      r_trig     <= 1'b0;
      r_underrun <= 1'b0;
      r_overlen  <= 1'b0;
    end else begin
      r_trig <= w_hs & (r_beat_cnt == '0);

      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_src      <= w_grant_idx;
            r_beat_cnt <= '0;
            r_state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + cnt_t'(1);
            if (w_sel_tlast || w_force_last) begin
              r_gap_cnt <= c_gap_load;
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == cnt_t'(1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - cnt_t'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A set event in the same cycle as err_clr takes priority.
      if (w_stream && !w_sel_tvalid && (r_beat_cnt != '0)) begin
        r_underrun <= 1'b1;
      end else if (err_clr) begin
        r_underrun <= 1'b0;
      end

      if (w_hs && w_force_last && !w_sel_tlast) begin
        r_overlen <= 1'b1;
      end else if (err_clr) begin
        r_overlen <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_dac_frame_arbiter.sv
`default_nettype none
// =============================================================================
// tb_axis_dac_frame_arbiter -- randomized scoreboard bench for the frame arbiter
// Revision: 1.0
// =============================================================================
module tb_axis_dac_frame_arbiter;

  localparam int W     = 32;
  localparam int GAP   = 16;
  localparam int MAXL  = 8;
  localparam int NFR   = 6;
  localparam int DEPTH = 128;
  localparam int LIMIT = 6000;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         first;
    logic         src;
  } exp_t;

  logic         aclk;
  logic         aresetn;
  logic [W-1:0] drv_data  [2];
  logic         drv_valid [2];
  logic         drv_last  [2];
  logic         s0_tready, s1_tready;
  logic         m_tready, m_tvalid, m_tlast;
  logic [W-1:0] m_tdata;
  logic         frame_trigger, frame_src, busy;
  logic         err_clr, underrun_err, overlen_err;

  int checks   = 0;
  int failures = 0;

  // Reference stimulus: per-source beat tables and the expected master stream.
  logic [W-1:0] sd  [2][DEPTH];
  bit           sl  [2][DEPTH];
  bit           scs [2][DEPTH];
  int           sn  [2];
  exp_t         exp_q[$];
  bit           exp_underrun;
  bit           exp_overlen;

  bit mon_en     = 1'b0;
  bit prev_first = 1'b0;
  int post_cnt   = 0;

  axis_dac_frame_arbiter #(
    .AXIS_TDATA_WIDTH (W),
    .GAP_CYCLES       (GAP),
    .MAX_FRAME_LEN    (MAXL)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s0_axis_tready (s0_tready),
    .s0_axis_tdata  (drv_data[0]),
    .s0_axis_tvalid (drv_valid[0]),
    .s0_axis_tlast  (drv_last[0]),
    .s1_axis_tready (s1_tready),
    .s1_axis_tdata  (drv_data[1]),
    .s1_axis_tvalid (drv_valid[1]),
    .s1_axis_tlast  (drv_last[1]),
    .m_axis_tready  (m_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .frame_trigger  (frame_trigger),
    .frame_src      (frame_src),
    .busy           (busy),
    .err_clr        (err_clr),
    .underrun_err   (underrun_err),
    .overlen_err    (overlen_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every master handshake and checks timing rules.
  always @(negedge aclk) begin
    if (mon_en) begin
      exp_t e;
      bit   hs_first;
      hs_first = 1'b0;
      chk("tready_exclusive", 64'(s0_tready & s1_tready), 64'd0);
      if (!busy) chk("tvalid_when_idle", 64'(m_tvalid), 64'd0);
      chk("frame_trigger", 64'(frame_trigger), 64'(prev_first));

      if (post_cnt > 0) begin
        if (post_cnt <= GAP) begin
          chk("gap_busy", 64'(busy), 64'd1);
          chk("gap_tvalid", 64'(m_tvalid), 64'd0);
          post_cnt++;
        end else begin
          chk("gap_end_idle", 64'(busy), 64'd0);
          post_cnt = 0;
        end
      end

      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_tdata), 64'(e.data));
          chk("beat_tlast", 64'(m_tlast), 64'(e.last));
          if (e.first) chk("frame_src", 64'(frame_src), 64'(e.src));
          hs_first = e.first;
          if (e.last) post_cnt = 1;
        end
      end
      prev_first = hs_first;
    end
  end

  initial begin
    int  idx [2];
    int  bub [2];
    bit  hs  [2];
    int  p   [2];
    int  cyc;
    int  k;
    int  n;
    bit  lg;
    int  s;
    exp_t e;

    aresetn  = 1'b1;
    m_tready = 1'b0;
    err_clr  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
      drv_data[i]  = '0;
    end

    // Build per-source frames; s0 opens with 1..4, s1 with an over-length frame.
    exp_overlen  = 1'b0;
    exp_underrun = 1'b0;
    for (int src = 0; src < 2; src++) begin
      sn[src] = 0;
      for (int f = 0; f < NFR; f++) begin
        int len;
        if (f == 0) len = (src == 0) ? 4 : 10;
        else        len = int'($urandom_range(1, 12));
        if (len > MAXL) exp_overlen = 1'b1;
        for (int j = 0; j < len; j++) begin
          sd[src][sn[src]]  = (src == 0 && f == 0) ? 32'(j + 1) : $urandom;
          sl[src][sn[src]]  = (j == len - 1);
          scs[src][sn[src]] = ((j % MAXL) == 0);
          sn[src]++;
        end
      end
    end

    // Frame-level model: both sources stay requesting, so grants alternate.
    p[0] = 0;
    p[1] = 0;
    lg   = 1'b1;
    while (p[0] < sn[0] || p[1] < sn[1]) begin
      if (p[0] < sn[0] && p[1] < sn[1]) s = lg ? 0 : 1;
      else                              s = (p[0] < sn[0]) ? 0 : 1;
      lg = (s == 1);
      k  = 0;
      do begin
        e.data  = sd[s][p[s]];
        e.last  = sl[s][p[s]] || (k == MAXL - 1);
        e.first = (k == 0);
        e.src   = (s == 1);
        exp_q.push_back(e);
        k++;
        p[s]++;
      end while (!e.last);
    end

    #2 aresetn = 1'b0;
    #1;
    chk("rst_s0_tready", 64'(s0_tready), 64'd0);
    chk("rst_s1_tready", 64'(s1_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_trigger", 64'(frame_trigger), 64'd0);
    chk("rst_frame_src", 64'(frame_src), 64'd0);
    chk("rst_errors", 64'({underrun_err, overlen_err}), 64'd0);

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    mon_en = 1'b1;

    // Driver: bubbles only inside a chunk, so arbitration order is untouched.
    idx[0] = 0; idx[1] = 0; bub[0] = 0; bub[1] = 0;
    cyc = 0;
    while ((idx[0] < sn[0] || idx[1] < sn[1]) && cyc < LIMIT) begin
      for (int i = 0; i < 2; i++) begin
        if (idx[i] < sn[i] && bub[i] == 0) begin
          drv_valid[i] = 1'b1;
          drv_data[i]  = sd[i][idx[i]];
          drv_last[i]  = sl[i][idx[i]];
        end else begin
          drv_valid[i] = 1'b0;
          drv_last[i]  = 1'b0;
        end
      end
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      hs[0] = drv_valid[0] && s0_tready;
      hs[1] = drv_valid[1] && s1_tready;
      @(posedge aclk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (bub[i] > 0) begin
          bub[i]--;
        end else if (hs[i]) begin
          idx[i]++;
          if (idx[i] < sn[i] && !scs[i][idx[i]] && $urandom_range(0, 3) == 0) begin
            bub[i]       = int'($urandom_range(1, 3));
            exp_underrun = 1'b1;
          end
        end
      end
    end
    if (cyc >= LIMIT) chk("driver_timeout", 64'd1, 64'd0);
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
    end
    m_tready = 1'b1;
    repeat (GAP + 4) @(posedge aclk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    @(negedge aclk);
    chk("underrun_flag", 64'(underrun_err), 64'(exp_underrun));
    chk("overlen_flag", 64'(overlen_err), 64'(exp_overlen));
    @(posedge aclk);
    #1 err_clr = 1'b1;
    @(posedge aclk);
    #1 err_clr = 1'b0;
    @(negedge aclk);
    chk("err_clr_underrun", 64'(underrun_err), 64'd0);
    chk("err_clr_overlen", 64'(overlen_err), 64'd0);

    // Reset in the middle of an s1 frame while beat 3 carries tlast.
    n   = 0;
    cyc = 0;
    drv_valid[1] = 1'b1;
    drv_data[1]  = 32'h0000_00A0;
    drv_last[1]  = 1'b0;
    while (n < 2 && cyc < 100) begin
      @(negedge aclk);
      if (s1_tready && drv_valid[1]) n++;
      @(posedge aclk);
      #1;
      drv_data[1] = 32'h0000_00A0 + 32'(n);
      drv_last[1] = (n == 2);
      cyc++;
    end
    chk("reset_setup_beats", 64'(n), 64'd2);
    @(negedge aclk);
    chk("pre_reset_src", 64'(frame_src), 64'd1);
    chk("pre_reset_tlast", 64'(m_tlast), 64'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_s1_tready", 64'(s1_tready), 64'd0);
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_m_tlast", 64'(m_tlast), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_frame_src", 64'(frame_src), 64'd0);

    drv_valid[0] = 1'b1;
    drv_data[0]  = 32'h5A5A_0001;
    drv_last[0]  = 1'b1;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    cyc = 0;
    n   = 0;
    while (n == 0 && cyc < 20) begin
      @(negedge aclk);
      if (m_tvalid && m_tready) begin
        n = 1;
        chk("post_rst_grant_data", 64'(m_tdata), 64'h5A5A_0001);
        chk("post_rst_grant_src", 64'(frame_src), 64'd0);
      end
      cyc++;
    end
    if (n == 0) chk("post_rst_timeout", 64'd1, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_dac_frame_arbiter.md
AXIS_DAC_FRAME_ARBITER -- requirements
Module: axis_dac_frame_arbiter

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, the data width of all streams.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, the idle cycles inserted after every frame (range 1..65535).
REQ-003 SHALL have parameter MAX_FRAME_LEN, default 4096, the beat limit per frame (range 2..65535).
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have s0_axis_tready output 1, s0_axis_tdata input AXIS_TDATA_WIDTH, s0_axis_tvalid input 1, s0_axis_tlast input 1: requester 0 (OFDM data frames).
REQ-007 SHALL have s1_axis_tready output 1, s1_axis_tdata input AXIS_TDATA_WIDTH, s1_axis_tvalid input 1, s1_axis_tlast input 1: requester 1 (preamble/test frames).
REQ-008 SHALL have m_axis_tready input 1, m_axis_tdata output AXIS_TDATA_WIDTH, m_axis_tvalid output 1, m_axis_tlast output 1: stream to the DAC interface.
REQ-009 SHALL have frame_trigger, output, 1 bit: one-cycle frame-start pulse for the ADC trigger.
REQ-010 SHALL have frame_src, output, 1 bit: index of the currently or most recently granted requester.
REQ-011 SHALL have busy, output, 1 bit: high in STREAM and GAP.
REQ-012 SHALL have err_clr input 1, underrun_err output 1 and overlen_err output 1: sticky error flags and their clear.

Function
REQ-013 SHALL implement FSM states IDLE, STREAM, GAP.
REQ-014 IDLE: when exactly one sN_axis_tvalid is high, SHALL grant N and enter STREAM on the next edge.
REQ-015 IDLE with both tvalid high: SHALL grant the requester not granted last (round-robin); the first grant after reset goes to s0.
REQ-016 STREAM: the granted slave SHALL pass combinationally to the master (tdata, tvalid, tlast; tready = m_axis_tready), zero latency.
REQ-017 The non-granted slave's tready SHALL be 0 in every state; both treadys and m_axis_tvalid SHALL be 0 in IDLE and GAP.
REQ-018 A 16-bit beat counter SHALL count master handshakes in STREAM, reset to 0 on each grant.
REQ-019 A handshake with tlast=1 SHALL end the frame and move STREAM to GAP.
REQ-020 The handshake where the counter reaches MAX_FRAME_LEN-1 without tlast SHALL force m_axis_tlast=1, set overlen_err and enter GAP; remaining source beats form a new frame later.
REQ-021 A STREAM cycle with granted tvalid=0 after the first beat SHALL set underrun_err; the state is unchanged.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles (down-counter), then enter IDLE; requests during GAP are held off, not lost.
REQ-023 frame_trigger SHALL be registered and high for exactly one cycle: the cycle after the first handshake of each frame.
REQ-024 err_clr=1 SHALL clear both flags; a set event in the same cycle SHALL win.
REQ-025 frame_src SHALL update on grant and hold through GAP and IDLE.

Reset
REQ-026 aresetn=0 SHALL immediately force state IDLE, counters 0, last-grant=1, frame_trigger=0, frame_src=0, busy=0, both errors=0, all treadys=0, m_axis_tvalid=0, m_axis_tlast=0.
REQ-027 Reset mid-frame SHALL abandon the frame without emitting tlast; the first grant after release follows REQ-015.

Structure
REQ-028 The FSM state encoding and the 16-bit counter width SHALL live in the shared package dac_ctrl_pkg.
REQ-029 The round-robin grant logic SHALL be the sub-module rr_arbiter2 (2 requesters, grant plus last-grant register); everything else is flat.

Verification
REQ-030 s0 sends a 4-beat frame (0x0001..0x0004, tlast on 4), m_tready=1: four output beats, tlast on beat 4, trigger one cycle after beat 1, then busy stays high 16 cycles.
REQ-031 s0 and s1 both valid from reset: s0 granted first, s1 after GAP, s0 again next; frame_src sequence is 0,1,0.
REQ-032 MAX_FRAME_LEN=8 with a 10-beat s1 frame: beat 8 carries forced tlast, overlen_err=1, and after GAP beats 9..10 appear as a new frame with a new trigger.
REQ-033 s0 drops tvalid for 3 cycles at beat 2: underrun_err=1, data unaltered, tlast still delivered; err_clr pulse then returns the flag to 0.
REQ-034 aresetn asserted at beat 3 of a frame: outputs take REQ-026 values in the same cycle; after release a pending s1 with s0 valid grants s0.
REQ-035 m_tready toggled 1/0 every cycle during a 6-beat frame: no beats lost or duplicated, counter equals 6 at tlast.
